mini_alu_core: RTL
==================

Name: mini_alu_core

Overview:
- Parametrised successor to the current single-issue MiniAlu datapath. It is a two-stage (fetch/latch, execute/writeback) core with configurable data width, register count and a multi-level call stack.
- It adds logic ops, shifts, BEQ, HALT, stack fault detection and a strobed output port.
- It sits between an external combinational instruction ROM and peripheral logic. The VGA, sprite and LED blocks consume oOut/oOutValid.

Parameters:
- DATA_W, 16, register/ALU data width.
- RA_W, 8, register address width; register file has 2^RA_W entries. INSTR_W = 4 + 3*RA_W (default 28).
- IP_W, 16, instruction pointer width.
- STACK_DEPTH, 4, call-stack entries (>=1).

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- oIP  out  IP_W  instruction address to ROM; ROM is combinational.
- iInstruction  in  INSTR_W  fields, MSB first: {op[3:0], dst[RA_W], src1[RA_W], src0[RA_W]}.
- oOut  out  DATA_W  value of last OUT instruction.
- oOutValid  out  1  one-cycle strobe per OUT.
- oStackFault  out  1  sticky; stack overflow/underflow seen.
- oHalted  out  1  core stopped by HALT.

Behaviour:
- Reset (Reset=0, async): IP=0, latched op=NOP, SP=0, oOut=0, oOutValid=0, oStackFault=0, oHalted=0, forwarding valid=0. Register file is not reset.
- Fetch edge: latch op/dst/src fields from iInstruction. Register file reads src0/src1 synchronously at the same edge; read-during-write returns the old value. IP <= oIP+1.
- oIP = branch target when the executing instruction takes a branch (combinational), else IP. Taken branches have zero penalty and no delay slot.
- Execute: results are written to reg[dst] on the next edge.
- Forwarding: if the previous executed instruction wrote register r and current src0/src1==r, use the previous result. Forwarding is ignored for immediate-form ops (STO, JMP, CALL).
- Opcodes:
  - 0 NOP.
  - 1 ADD: s1+s0.
  - 2 SUB: s1-s0.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: s1 << s0[log2(DATA_W)-1:0].
  - 7 SHR: logical shift, same amount rule.
  - 8 BLE: branch to dst if s1<=s0, unsigned.
  - 9 BEQ: branch to dst if s1==s0.
  - A JMP: branch to dst.
  - B CALL: push IP+1 of the CALL, branch to dst.
  - C RET: pop, branch to popped address.
  - D OUT: oOut<=s1, oOutValid=1 for one cycle.
  - E STO: reg[dst] <= zero-extended {src1,src0}, truncated to DATA_W.
  - F HALT.
- Arithmetic and shifts wrap modulo 2^DATA_W. Branch target is dst zero-extended to IP_W.
- Call stack full (SP==STACK_DEPTH) and CALL: no push, no branch (falls through), oStackFault<=1.
- Call stack empty and RET: no branch, oStackFault<=1.
- oStackFault clears only on reset.
- HALT: oHalted<=1 at the end-of-execute edge. IP freezes at the value already incremented. Every later latched op is forced to NOP; no writes, OUT or stack changes occur until reset.
- Reset asserted mid-execution: pending writeback, OUT strobe and push/pop are discarded.

Test Plan:
- STO r1=5; STO r2=7; ADD r3=r2+r1; OUT r3 -> oOut=12, oOutValid high exactly one cycle, 4 cycles after the first fetch edge.
- Back-to-back dependency: STO r1=3; ADD r1=r1+r1; ADD r1=r1+r1; OUT r1 -> oOut=12 (forwarding on each hop, no stall).
- BLE: r1=2, r2=9, BLE to 0x20 with s1=r1, s0=r2 -> oIP=0x20 in the execute cycle; the instruction at fall-through address is never executed. Swapped operands -> not taken.
- CALL nesting with STACK_DEPTH=4: 4 nested CALLs then 4 RETs -> each returns to CALL addr+1. A 5th CALL -> falls through, oStackFault=1. RET with empty stack -> fall through, fault stays 1.
- Width/wrap at DATA_W=8: STO r1=0xFF; STO r2=1; ADD -> 0x00; SHL r1 by 9 -> shift amount 1 -> 0xFE.
- HALT then OUT in ROM -> oHalted=1, no further oOutValid, oIP constant. Assert Reset low mid-run -> oIP=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage (fetch/latch, execute/writeback) accumulator-free
// register machine with a call stack, logic/shift ops, HALT and a strobed
// output port.
//
// Ports:
//   Clock        - single clock, rising-edge state updates
//   Reset        - asynchronous, active-low
//   oIP          - instruction address to the combinational ROM
//   iInstruction - {op[3:0], dst[RA_W], src1[RA_W], src0[RA_W]}
//   oOut         - value of the most recent OUT
//   oOutValid    - one-cycle strobe per OUT
//   oStackFault  - sticky stack overflow/underflow flag
//   oHalted      - core stopped by HALT
module mini_alu_core #(
    parameter int DATA_W      = 16,
    parameter int RA_W        = 8,
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4,
    localparam int INSTR_W    = 4 + 3*RA_W
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [IP_W-1:0]    oIP,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [DATA_W-1:0]  oOut,
    output logic               oOutValid,
    output logic               oStackFault,
    output logic               oHalted
);
    localparam int SHW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
        OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
        OP_BLE  = 4'h8, OP_BEQ  = 4'h9, OP_JMP  = 4'hA, OP_CALL = 4'hB,
        OP_RET  = 4'hC, OP_OUT  = 4'hD, OP_STO  = 4'hE, OP_HALT = 4'hF
    } op_t;

    // instruction fields as presented by the ROM this cycle
    logic [3:0]      op_f;
    logic [RA_W-1:0] dst_f, src1_f, src0_f;

    assign op_f   = iInstruction[INSTR_W-1 -: 4];
    assign dst_f  = iInstruction[3*RA_W-1 -: RA_W];
    assign src1_f = iInstruction[2*RA_W-1 -: RA_W];
    assign src0_f = iInstruction[RA_W-1:0];

    // latched (executing) instruction
    op_t             op_q;
    logic [RA_W-1:0] dst_q, src1_q, src0_q;
    logic [DATA_W-1:0] rd1_q, rd0_q;

    logic [IP_W-1:0] ip_q;
    logic [SP_W-1:0] sp_q;
    logic [IP_W-1:0] stack_mem [STACK_DEPTH];
    logic [DATA_W-1:0] regs [2**RA_W];

    // previous instruction's writeback, covering the read-during-write hole
    logic              fwd_vld;
    logic [RA_W-1:0]   fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    logic              is_imm;
    logic [DATA_W-1:0] s1, s0;
    logic [DATA_W-1:0] result;
    logic              wr_en, br_taken, push, pop, fault_set, out_en, halt_set;
    logic [IP_W-1:0]   br_target;
    logic [SI_W-1:0]   push_idx, top_idx;
    logic              frozen;

    assign is_imm = (op_q == OP_STO) || (op_q == OP_JMP) || (op_q == OP_CALL);
    assign s1 = (!is_imm && fwd_vld && fwd_addr == src1_q) ? fwd_data : rd1_q;
    assign s0 = (!is_imm && fwd_vld && fwd_addr == src0_q) ? fwd_data : rd0_q;

    assign push_idx = SI_W'(sp_q);
    assign top_idx  = SI_W'(sp_q - SP_W'(1));

    always_comb begin
        result    = '0;
        wr_en     = 1'b0;
        br_taken  = 1'b0;
        br_target = IP_W'(dst_q);
        push      = 1'b0;
        pop       = 1'b0;
        fault_set = 1'b0;
        out_en    = 1'b0;
        halt_set  = 1'b0;
        case (op_q)
            OP_NOP:  ;
            OP_ADD:  begin wr_en = 1'b1; result = s1 + s0; end
            OP_SUB:  begin wr_en = 1'b1; result = s1 - s0; end
            OP_AND:  begin wr_en = 1'b1; result = s1 & s0; end
            OP_OR:   begin wr_en = 1'b1; result = s1 | s0; end
            OP_XOR:  begin wr_en = 1'b1; result = s1 ^ s0; end
            OP_SHL:  begin wr_en = 1'b1; result = s1 << s0[SHW-1:0]; end
            OP_SHR:  begin wr_en = 1'b1; result = s1 >> s0[SHW-1:0]; end
            OP_BLE:  br_taken = (s1 <= s0);
            OP_BEQ:  br_taken = (s1 == s0);
            OP_JMP:  br_taken = 1'b1;
            OP_CALL: begin
                // full stack: no push and no branch, just flag it
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    fault_set = 1'b1;
                end else begin
                    push     = 1'b1;
                    br_taken = 1'b1;
                end
            end
            OP_RET: begin
                if (sp_q == '0) begin
                    fault_set = 1'b1;
                end else begin
                    pop       = 1'b1;
                    br_taken  = 1'b1;
                    br_target = stack_mem[top_idx];
                end
            end
            OP_OUT:  out_en = 1'b1;
            OP_STO:  begin wr_en = 1'b1; result = DATA_W'({src1_q, src0_q}); end
            OP_HALT: halt_set = 1'b1;
        endcase
    end

    // taken branches redirect the ROM in the same cycle: zero penalty
    assign oIP = br_taken ? br_target : ip_q;

    // once HALT is executing nothing new is latched and IP stops moving
    assign frozen = oHalted || (op_q == OP_HALT);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ip_q        <= '0;
            op_q        <= OP_NOP;
            dst_q       <= '0;
            src1_q      <= '0;
            src0_q      <= '0;
            sp_q        <= '0;
            fwd_vld     <= 1'b0;
            fwd_addr    <= '0;
            fwd_data    <= '0;
            oOut        <= '0;
            oOutValid   <= 1'b0;
            oStackFault <= 1'b0;
            oHalted     <= 1'b0;
        end else begin
            if (!frozen) begin
                ip_q <= oIP + IP_W'(1);
                op_q <= op_t'(op_f);
            end else begin
                op_q <= OP_NOP;
            end
            dst_q    <= dst_f;
            src1_q   <= src1_f;
            src0_q   <= src0_f;
            fwd_vld  <= wr_en;
            fwd_addr <= dst_q;
            fwd_data <= result;
            if (push) sp_q <= sp_q + SP_W'(1);
            if (pop)  sp_q <= sp_q - SP_W'(1);
            if (fault_set) oStackFault <= 1'b1;
            oOutValid <= out_en;
            if (out_en) oOut <= s1;
            if (halt_set) oHalted <= 1'b1;
        end
    end

    // storage without reset; enables derive from op_q, which reset clears
    always_ff @(posedge Clock) begin
        if (wr_en) regs[dst_q] <= result;
        rd1_q <= regs[src1_f];
        rd0_q <= regs[src0_f];
        if (push) stack_mem[push_idx] <= ip_q;
    end

endmodule
